// File: rtl/turbo_clkgen.sv
// rtl/turbo_clkgen.sv - CPU clock-enable generator with glitch-free speed switching
// Speed changes are deferred to phase 7, where every speed pulses, then requests are frozen while settling.
module turbo_clkgen #(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] turbo_enable,
  input  logic       lock_slow,
  input  logic       bus_idle,
  output logic       cpu_ce,
  output logic [1:0] current_speed,
  output logic       switching
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PENDING = 2'd1,
    SETTLE  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] phase_q, phase_d;
  logic [1:0] speed_q, speed_d;
  logic [1:0] target_q, target_d;
  logic [3:0] settle_q, settle_d;
  logic [1:0] request;
  logic       ce_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      phase_q  <= 3'd0;
      speed_q  <= 2'b00;
      target_q <= 2'b00;
      settle_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      speed_q  <= speed_d;
      target_q <= target_d;
      settle_q <= settle_d;
    end
  end

  always_comb begin
    request  = lock_slow ? 2'b00 : turbo_enable;
    phase_d  = phase_q + 3'd1;
    state_d  = state_q;
    speed_d  = speed_q;
    target_d = target_q;
    settle_d = settle_q;
    case (state_q)
      RUN: begin
        if (request != speed_q) begin
          target_d = request;
          state_d  = PENDING;
        end
      end
      PENDING: begin
        target_d = request;
        if (request == speed_q) begin
          state_d = RUN;
        end else if (phase_q == 3'd7 && bus_idle) begin
          // Old speed's phase-7 pulse is this cycle; new speed starts cleanly at phase 0.
          speed_d  = target_q;
          settle_d = SETTLE_LOAD;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_q == 4'd0) begin
          state_d = RUN;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    ce_raw = 1'b0;
    case (speed_q)
      2'b00:   ce_raw = (phase_q == 3'd7);
      2'b01:   ce_raw = (phase_q[1:0] == 2'b11);
      2'b10:   ce_raw = phase_q[0];
      default: ce_raw = 1'b1;
    endcase
  end

  assign cpu_ce        = ce_raw & ~rst;
  assign current_speed = speed_q;
  assign switching     = (state_q != RUN);

endmodule

// File: tb/tb_turbo_clkgen.sv
// tb/tb_turbo_clkgen.sv - scoreboard bench for turbo_clkgen
module tb_turbo_clkgen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] turbo_enable = 2'b00;
  logic       lock_slow = 1'b0;
  logic       bus_idle = 1'b1;
  logic       cpu_ce;
  logic [1:0] current_speed;
  logic       switching;

  typedef struct packed {
    logic       ce;
    logic [1:0] spd;
    logic       sw;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [2:0] ph = 3'd0;
  logic [2:0] plan_ph = 3'd0;

  always #5 clk = ~clk;

  turbo_clkgen #(.SETTLE_CYCLES(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .turbo_enable  (turbo_enable),
    .lock_slow     (lock_slow),
    .bus_idle      (bus_idle),
    .cpu_ce        (cpu_ce),
    .current_speed (current_speed),
    .switching     (switching)
  );

  // Speed s divides the 8-phase frame into periods of 8>>s, pulsing on the last phase of each.
  function automatic logic exp_ce(logic [1:0] spd, logic [2:0] p);
    int period;
    period = 8 >> spd;
    return ((int'(p) + 1) % period) == 0;
  endfunction

  task automatic push_n(int n, logic [1:0] spd, logic sw);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.ce  = exp_ce(spd, plan_ph);
      e.spd = spd;
      e.sw  = sw;
      exp_q.push_back(e);
      plan_ph = plan_ph + 3'd1;
    end
  endtask

  task automatic push_one(logic ce, logic [1:0] spd, logic sw);
    exp_t e;
    e.ce  = ce;
    e.spd = spd;
    e.sw  = sw;
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    logic r;
    r = rst;
    @(posedge clk);
    @(negedge clk);
    ph = r ? 3'd0 : ph + 3'd1;
  endtask

  task automatic wait_phase(logic [2:0] p);
    for (int k = 0; k < 8 && ph != p; k++) next_cycle();
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    turbo_enable = 2'b00;
    lock_slow = 1'b0;
    bus_idle = 1'b1;
    next_cycle();
    next_cycle();
    checks++;
    if ({cpu_ce, current_speed, switching} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: got ce=%b spd=%b sw=%b, want ce=0 spd=00 sw=0",
               cpu_ce, current_speed, switching);
    end
    rst = 1'b0;
    plan_ph = ph;
    push_n(24, 2'b00, 1'b0);
    for (int i = 0; i < 24; i++) begin
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL reset_run[%0d]: scoreboard empty", i);
      end else begin
        e = exp_q.pop_front();
        if ({cpu_ce, current_speed, switching} !== {e.ce, e.spd, e.sw}) begin
          errors++;
          $display("FAIL reset_run[%0d]: got ce=%b spd=%b sw=%b, want ce=%b spd=%b sw=%b",
                   i, cpu_ce, current_speed, switching, e.ce, e.spd, e.sw);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_switch_10();
    exp_t e;
    wait_phase(3'd2);
    plan_ph = ph;
    push_n(1, 2'b00, 1'b0);
    push_n(5, 2'b00, 1'b1);
    push_n(16, 2'b10, 1'b1);
    push_n(8, 2'b10, 1'b0);
    for (int i = 0; i < 30; i++) begin
      if (i == 0) turbo_enable = 2'b10;
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL switch_10[%0d]: scoreboard empty", i);
      end else begin
        e = exp_q.pop_front();
        if ({cpu_ce, current_speed, switching} !== {e.ce, e.spd, e.sw}) begin
          errors++;
          $display("FAIL switch_10[%0d]: got ce=%b spd=%b sw=%b, want ce=%b spd=%b sw=%b",
                   i, cpu_ce, current_speed, switching, e.ce, e.spd, e.sw);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_bus_idle();
    exp_t e;
    wait_phase(3'd0);
    plan_ph = ph;
    push_n(1, 2'b10, 1'b0);
    push_n(23, 2'b10, 1'b1);
    push_n(16, 2'b01, 1'b1);
    push_n(8, 2'b01, 1'b0);
    for (int i = 0; i < 48; i++) begin
      if (i == 0) begin
        turbo_enable = 2'b01;
        bus_idle = 1'b0;
      end
      if (i == 16) bus_idle = 1'b1;
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL bus_idle[%0d]: scoreboard empty", i);
      end else begin
        e = exp_q.pop_front();
        if ({cpu_ce, current_speed, switching} !== {e.ce, e.spd, e.sw}) begin
          errors++;
          $display("FAIL bus_idle[%0d]: got ce=%b spd=%b sw=%b, want ce=%b spd=%b sw=%b",
                   i, cpu_ce, current_speed, switching, e.ce, e.spd, e.sw);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_lock();
    exp_t e;
    wait_phase(3'd0);
    plan_ph = ph;
    push_n(1, 2'b01, 1'b0);
    push_n(7, 2'b01, 1'b1);
    push_n(16, 2'b00, 1'b1);
    push_n(8, 2'b00, 1'b0);
    push_n(1, 2'b00, 1'b0);
    push_n(7, 2'b00, 1'b1);
    push_n(16, 2'b11, 1'b1);
    push_n(8, 2'b11, 1'b0);
    for (int i = 0; i < 64; i++) begin
      if (i == 0) begin
        turbo_enable = 2'b11;
        lock_slow = 1'b1;
      end
      if (i == 32) lock_slow = 1'b0;
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL lock_slow[%0d]: scoreboard empty", i);
      end else begin
        e = exp_q.pop_front();
        if ({cpu_ce, current_speed, switching} !== {e.ce, e.spd, e.sw}) begin
          errors++;
          $display("FAIL lock_slow[%0d]: got ce=%b spd=%b sw=%b, want ce=%b spd=%b sw=%b",
                   i, cpu_ce, current_speed, switching, e.ce, e.spd, e.sw);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_settle();
    exp_t e;
    wait_phase(3'd0);
    plan_ph = ph;
    push_n(1, 2'b11, 1'b0);
    push_n(7, 2'b11, 1'b1);
    push_n(5, 2'b10, 1'b1);
    push_one(1'b0, 2'b10, 1'b1);
    push_one(1'b0, 2'b00, 1'b0);
    plan_ph = 3'd0;
    push_n(1, 2'b00, 1'b0);
    push_n(7, 2'b00, 1'b1);
    push_n(16, 2'b10, 1'b1);
    push_n(8, 2'b10, 1'b0);
    for (int i = 0; i < 47; i++) begin
      if (i == 0) turbo_enable = 2'b10;
      if (i == 13) rst = 1'b1;
      if (i == 15) rst = 1'b0;
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL reset_settle[%0d]: scoreboard empty", i);
      end else begin
        e = exp_q.pop_front();
        if ({cpu_ce, current_speed, switching} !== {e.ce, e.spd, e.sw}) begin
          errors++;
          $display("FAIL reset_settle[%0d]: got ce=%b spd=%b sw=%b, want ce=%b spd=%b sw=%b",
                   i, cpu_ce, current_speed, switching, e.ce, e.spd, e.sw);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_cancel();
    exp_t e;
    rst = 1'b1;
    turbo_enable = 2'b00;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    plan_ph = ph;
    push_n(2, 2'b00, 1'b0);
    push_n(2, 2'b00, 1'b1);
    push_n(20, 2'b00, 1'b0);
    for (int i = 0; i < 24; i++) begin
      if (i == 1) turbo_enable = 2'b01;
      if (i == 3) turbo_enable = 2'b00;
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL cancel[%0d]: scoreboard empty", i);
      end else begin
        e = exp_q.pop_front();
        if ({cpu_ce, current_speed, switching} !== {e.ce, e.spd, e.sw}) begin
          errors++;
          $display("FAIL cancel[%0d]: got ce=%b spd=%b sw=%b, want ce=%b spd=%b sw=%b",
                   i, cpu_ce, current_speed, switching, e.ce, e.spd, e.sw);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_switch_10();
    test_bus_idle();
    test_lock();
    test_reset_settle();
    test_cancel();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/turbo_clkgen.md
TURBO_CLKGEN -- requirements
Module: turbo_clkgen

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16: master clocks during which new speed requests are ignored after a speed change (range 1..16).
REQ-002 SHALL have port clk, input, 1: master clock (28 MHz), all logic on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port turbo_enable, input, 2: requested CPU speed from the scandoubler control register (00=3.5, 01=7, 10=14, 11=28 MHz).
REQ-005 SHALL have port lock_slow, input, 1: when high, forces a 3.5 MHz request regardless of turbo_enable.
REQ-006 SHALL have port bus_idle, input, 1: high when the CPU is not mid memory/IO cycle and a switch is permitted.
REQ-007 SHALL have port cpu_ce, output, 1: one-clk CPU clock-enable pulse.
REQ-008 SHALL have port current_speed, output, 2: speed code in effect.
REQ-009 SHALL have port switching, output, 1: high whenever state is not RUN.

Function
REQ-010 SHALL hold a free-running 3-bit phase counter, +1 every clk, wrapping 7->0.
REQ-011 SHALL decode cpu_ce combinationally from registers: speed 00 when phase==7; 01 when phase[1:0]==3; 10 when phase[0]==1; 11 every clk.
REQ-012 SHALL force cpu_ce low in any cycle where rst is high.
REQ-013 SHALL form request = lock_slow ? 00 : turbo_enable, sampled every clk.
REQ-014 SHALL implement states RUN, PENDING, SETTLE.
REQ-015 RUN: if request != current_speed, SHALL latch target<=request and go PENDING next clk; else stay RUN.
REQ-016 PENDING: target SHALL track request every clk (latest value wins).
REQ-017 PENDING: if request == current_speed, SHALL return to RUN without change.
REQ-018 PENDING: when phase==7 and bus_idle==1 (and REQ-017 not met), SHALL on that edge load current_speed<=target, load settle counter with SETTLE_CYCLES-1, go SETTLE.
REQ-019 Switch phase rule: since every speed pulses cpu_ce at phase 7, the switch cycle SHALL emit exactly one cpu_ce under the old speed; first new-speed pulse follows per REQ-011 from phase 0; no truncated or doubled pulse.
REQ-020 PENDING with bus_idle==0 at phase 7 SHALL remain PENDING and retry at the next phase 7.
REQ-021 SETTLE: counter SHALL decrement each clk; request ignored; at count 0 SHALL go RUN next clk.
REQ-022 current_speed SHALL change only on the REQ-018 edge.
REQ-023 Counter widths: phase 3 bits, settle 4 bits, no overflow beyond stated wrap.

Reset
REQ-024 On rst high at a clk edge: phase<=0, current_speed<=00, target<=00, settle<=0, state<=RUN, so switching=0; cpu_ce=0 while rst high.
REQ-025 Reset mid-PENDING or mid-SETTLE SHALL abandon the switch; after release, a nonzero request SHALL start a fresh RUN->PENDING sequence.
REQ-026 First cpu_ce after release at speed 00 SHALL occur in the 8th clk (phase==7).

Verification
REQ-027 Reset release, turbo=00, lock_slow=0, bus_idle=1 -> cpu_ce on clks 8,16,24...; current_speed=00; switching=0.
REQ-028 At phase 2 set turbo=10 -> switching=1 next clk; switch edge at phase 7; then cpu_ce every 2 clks (phases 1,3,5,7); switching stays 1 for 16 clks after the switch edge then 0.
REQ-029 turbo=01 with bus_idle=0 across two phase-7 events, then 1 -> switch at the third phase 7 only; no cpu_ce gaps or extras.
REQ-030 turbo=11, lock_slow=1 -> current_speed stays/returns to 00; drop lock_slow -> switches to 11, cpu_ce every clk.
REQ-031 In PENDING toggle turbo 00->01->00 before phase 7 -> returns to RUN, current_speed remains 00, period 8 unbroken.
REQ-032 rst pulsed during SETTLE after switch to 10 -> current_speed=00, switching=0, cpu_ce low during rst, first pulse 8th clk after release.
